// File: rtl/tcs34725_i2c_responder.sv
// rtl/tcs34725_i2c_responder.sv - I2C target emulating the TCS34725 colour sensor register reads
// Optional feature macro: TCS_RESP_WRITE_EN (ACK and store data bytes written to ENABLE/ATIME)
// Ports:
//   clk, rst                 system clock (>=8x SCL), asynchronous active-high reset
//   scl, sda_in              I2C bus inputs, synchronised internally
//   sda_oe                   1 = pull SDA low (open-drain), 0 = release
//   clear_in..blue_in        channel values, snapshotted when a read address is accepted
//   valid_in                 served as STATUS[0] (AVALID), snapshotted with the channels
//   busy                     high while this target is addressed, until STOP
//   rd_strobe                one-cycle pulse after each transmitted data byte
module tcs34725_i2c_responder #(
    parameter logic [6:0] DEV_ADDR    = 7'h29,
    parameter logic [7:0] ID_VAL      = 8'h44,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] clear_in,
    input  logic [15:0] red_in,
    input  logic [15:0] green_in,
    input  logic [15:0] blue_in,
    input  logic        valid_in,
    output logic        busy,
    output logic        rd_strobe
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det, bus_evt, byte_done;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d, tx_q, tx_d, rd_data;
    logic [4:0]  reg_ptr_q, reg_ptr_d;
    logic        ack_q, ack_d, sda_oe_q, sda_oe_d, busy_q, busy_d, rd_strobe_q, rd_strobe_d;
    logic        snap_load;
    logic [15:0] snap_clear, snap_red, snap_green, snap_blue;
    logic        snap_valid;
    logic [7:0]  enable_q, atime_q;

    // Synchronisers reset to the idle bus level so reset release never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign bus_evt   = start_det | stop_det;
    // The 8th SCL fall of a received byte: the ACK/NACK decision point.
    assign byte_done = scl_fall & (bit_cnt_q == 4'd8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_clear <= '0;
            snap_red   <= '0;
            snap_green <= '0;
            snap_blue  <= '0;
            snap_valid <= 1'b0;
        end else if (snap_load) begin
            snap_clear <= clear_in;
            snap_red   <= red_in;
            snap_green <= green_in;
            snap_blue  <= blue_in;
            snap_valid <= valid_in;
        end
    end

`ifdef TCS_RESP_WRITE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= '0;
            atime_q  <= '0;
        end else if (state_q == WDATA && byte_done && !bus_evt) begin
            if (reg_ptr_q == 5'h00) enable_q <= shreg_q;
            else if (reg_ptr_q == 5'h01) atime_q <= shreg_q;
        end
    end
`else
    assign enable_q = 8'h00;
    assign atime_q  = 8'h00;
`endif

    always_comb begin
        case (reg_ptr_q)
            5'h00:   rd_data = enable_q;
            5'h01:   rd_data = atime_q;
            5'h12:   rd_data = ID_VAL;
            5'h13:   rd_data = {7'b0, snap_valid};
            5'h14:   rd_data = snap_clear[7:0];
            5'h15:   rd_data = snap_clear[15:8];
            5'h16:   rd_data = snap_red[7:0];
            5'h17:   rd_data = snap_red[15:8];
            5'h18:   rd_data = snap_green[7:0];
            5'h19:   rd_data = snap_green[15:8];
            5'h1A:   rd_data = snap_blue[7:0];
            5'h1B:   rd_data = snap_blue[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            tx_q        <= '0;
            reg_ptr_q   <= '0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            reg_ptr_q   <= reg_ptr_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        reg_ptr_d   = reg_ptr_q;
        ack_d       = ack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rd_strobe_d = 1'b0;
        snap_load   = 1'b0;
        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps reg_ptr so a pointer write can be followed by a read.
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            if ((state_q == ADDR || state_q == CMD || state_q == WDATA) &&
                scl_rise && bit_cnt_q != 4'd8) begin
                shreg_d   = {shreg_q[6:0], sda_s};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                ADDR: if (byte_done) begin
                    bit_cnt_d = 4'd0;
                    if (shreg_q[7:1] == DEV_ADDR) begin
                        state_d   = ADDR_ACK;
                        sda_oe_d  = 1'b1;
                        busy_d    = 1'b1;
                        snap_load = shreg_q[0];
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (shreg_q[0]) begin
                        tx_d     = rd_data;
                        sda_oe_d = ~rd_data[7];
                        state_d  = RDATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = CMD;
                    end
                end
                CMD: if (byte_done) begin
                    bit_cnt_d = 4'd0;
                    if (shreg_q[7]) begin
                        reg_ptr_d = shreg_q[4:0];
                        sda_oe_d  = 1'b1;
                        state_d   = CMD_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CMD_ACK: if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    state_d  = WDATA;
                end
                WDATA: if (byte_done) begin
                    bit_cnt_d = 4'd0;
`ifdef TCS_RESP_WRITE_EN
                    sda_oe_d  = 1'b1;
                    state_d   = WDATA_ACK;
`else
                    state_d   = IDLE;
`endif
                end
                WDATA_ACK: if (scl_fall) begin
                    sda_oe_d  = 1'b0;
                    reg_ptr_d = reg_ptr_q + 5'd1;
                    state_d   = WDATA;
                end
                // sda_oe is the inverse of the bit: a 0 bit pulls the line low.
                RDATA: if (scl_fall) begin
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d   = 4'd0;
                        sda_oe_d    = 1'b0;
                        rd_strobe_d = 1'b1;
                        state_d     = RDATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = {tx_q[6:0], 1'b0};
                        sda_oe_d  = ~tx_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_s;
                        if (!sda_s) reg_ptr_d = reg_ptr_q + 5'd1;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            tx_d     = rd_data;
                            sda_oe_d = ~rd_data[7];
                            state_d  = RDATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign rd_strobe = rd_strobe_q;
endmodule

// File: tb/tb_tcs34725_i2c_responder.sv
// tb/tb_tcs34725_i2c_responder.sv - randomized scoreboard bench for tcs34725_i2c_responder
module tb_tcs34725_i2c_responder;
    localparam int Q = 50;
    localparam logic [6:0] DEV = 7'h29;

    logic clk = 1'b0;
    logic rst, scl, m_sda, sda_line;
    logic sda_oe, busy, rd_strobe, valid_in;
    logic [15:0] clear_in, red_in, green_in, blue_in;

    assign sda_line = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    tcs34725_i2c_responder dut (
        .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .clear_in(clear_in), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .valid_in(valid_in), .busy(busy), .rd_strobe(rd_strobe)
    );

    int n_checks = 0;
    int n_pass = 0;
    int oe_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] mon_exp;

    logic [15:0] m_ch[4];
    logic m_valid = 1'b0;
    logic [7:0] m_enable = 8'h00;
    logic [7:0] m_atime = 8'h00;
    logic [4:0] m_ptr = 5'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] model_reg(input int p);
        int a;
        a = p & 31;
        if (a == 0) return m_enable;
        if (a == 1) return m_atime;
        if (a == 'h12) return 8'h44;
        if (a == 'h13) return {7'b0, m_valid};
        if (a >= 'h14 && a <= 'h1B) return m_ch[(a - 'h14) / 2][8 * ((a - 'h14) % 2) +: 8];
        return 8'h00;
    endfunction

    // Monitor: collect bus bits on SCL rise, compare a byte whenever the DUT strobes.
    always @(posedge scl) mon_sh <= {mon_sh[6:0], sda_line};
    always @(negedge clk) begin
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (rd_strobe) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected_strobe", 32'(mon_sh), 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_byte", 32'(mon_sh), 32'(mon_exp));
            end
        end
    end

    task automatic bus_start();
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; m_sda = 1'b0; #Q; scl = 1'b0; #Q;
    endtask
    task automatic bus_stop();
        m_sda = 1'b0; #Q; scl = 1'b1; #Q; m_sda = 1'b1; #(2 * Q);
    endtask
    task automatic write_bit(input logic b);
        m_sda = b; #Q; scl = 1'b1; #(2 * Q); scl = 1'b0; #Q;
    endtask
    task automatic read_bit(output logic b);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
    endtask
    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask
    task automatic read_byte(input logic send_ack);
        logic b;
        for (int i = 0; i < 8; i++) read_bit(b);
        write_bit(~send_ack);
    endtask

    task automatic read_phase(input int n, input bit chg, input logic [15:0] red_new);
        logic a;
        m_ch[0] = clear_in; m_ch[1] = red_in; m_ch[2] = green_in; m_ch[3] = blue_in;
        m_valid = valid_in;
        write_byte({DEV, 1'b1}, a);
        check("addr_r_ack", a, 1);
        check("busy_addressed", busy, 1);
        for (int i = 0; i < n; i++) exp_q.push_back(model_reg(int'(m_ptr) + i));
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1);
            if (chg && i == 0) red_in = red_new;
        end
        m_ptr = m_ptr + 5'(n - 1);
    endtask

    task automatic set_ptr(input logic [4:0] ptr);
        logic a;
        write_byte({DEV, 1'b0}, a);
        check("addr_w_ack", a, 1);
        write_byte({3'b100, ptr}, a);
        check("cmd_ack", a, 1);
        m_ptr = ptr;
    endtask

    task automatic do_read(input logic [4:0] ptr, input int n, input bit chg, input logic [15:0] red_new);
        bus_start();
        set_ptr(ptr);
        bus_start();
        read_phase(n, chg, red_new);
        bus_stop();
        check("busy_after_stop", busy, 0);
    endtask

    task automatic do_write(input logic [4:0] ptr, input int n, input logic [7:0] b0, input logic [7:0] b1);
        logic a;
        logic [7:0] b;
        bus_start();
        set_ptr(ptr);
        for (int i = 0; i < n; i++) begin
            b = (i == 0) ? b0 : b1;
            write_byte(b, a);
`ifdef TCS_RESP_WRITE_EN
            check("wdata_ack", a, 1);
            if (m_ptr == 5'h00) m_enable = b;
            else if (m_ptr == 5'h01) m_atime = b;
            m_ptr = m_ptr + 5'd1;
`else
            check("wdata_nack", a, 0);
            break;
`endif
        end
        bus_stop();
    endtask

    task automatic do_bad_addr(input logic [6:0] addr);
        logic a;
        int c0;
        bus_start();
        c0 = oe_cnt;
        write_byte({addr, 1'b0}, a);
        check("bad_addr_nack", a, 0);
        check("bad_addr_busy", busy, 0);
        write_byte(8'h00, a);
        check("bad_addr_oe_quiet", oe_cnt - c0, 0);
        bus_stop();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic a;
        logic [6:0] bad;
        rst = 1'b1; scl = 1'b1; m_sda = 1'b1; valid_in = 1'b0;
        clear_in = '0; red_in = '0; green_in = '0; blue_in = '0;
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_strobe", rd_strobe, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        red_in = 16'hBEEF; valid_in = 1'b1;
        do_read(5'h16, 2, 1'b0, 16'h0);

        do_bad_addr(7'h30);

        red_in = 16'hA55A;
        bus_start(); set_ptr(5'h16); bus_stop();
        bus_start();
        write_byte({DEV, 1'b0}, a); check("addr_w_ack", a, 1);
        write_byte(8'h16, a); check("cmd_bit7_nack", a, 0);
        bus_stop();
        bus_start(); read_phase(2, 1'b0, 16'h0); bus_stop();

        red_in = 16'h1234;
        do_read(5'h16, 2, 1'b1, 16'h5678);

        clear_in = 16'd1; red_in = 16'd2; green_in = 16'd3; blue_in = 16'd4;
        do_read(5'h14, 13, 1'b0, 16'h0);
        do_read(5'h1F, 20, 1'b0, 16'h0);

        clear_in = 16'h0000;
        bus_start(); set_ptr(5'h14); bus_start();
        write_byte({DEV, 1'b1}, a); check("addr_r_ack", a, 1);
        m_sda = 1'b1; #Q; scl = 1'b1; #Q;
        check("oe_driving_zero", sda_oe, 1);
        #2; rst = 1'b1;
        #1; check("oe_async_release", sda_oe, 0);
        check("busy_in_rst", busy, 0);
        #7; #Q; rst = 1'b0; scl = 1'b0; #Q;
        m_ptr = 5'h00; m_enable = 8'h00; m_atime = 8'h00;
        do_read(5'h12, 2, 1'b0, 16'h0);

        do_write(5'h00, 1, 8'h03, 8'h00);
        do_read(5'h00, 1, 1'b0, 16'h0);

        for (int t = 0; t < 10; t++) begin
            clear_in = 16'($urandom); red_in = 16'($urandom);
            green_in = 16'($urandom); blue_in = 16'($urandom); valid_in = 1'($urandom);
            case ($urandom_range(0, 3))
                0, 1: do_read(5'($urandom), int'($urandom_range(1, 5)), 1'b0, 16'h0);
                2: do_write(5'($urandom_range(0, 2)), int'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));
                default: begin
                    bad = 7'($urandom);
                    if (bad == DEV) bad = 7'h2A;
                    do_bad_addr(bad);
                end
            endcase
            do_read(5'h00, 2, 1'b0, 16'h0);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
